// File: rtl/segmented_health_bar.sv
// rtl/segmented_health_bar.sv - HUD health bar drawn as discrete HP segments with damage/heal/invulnerability FSM
//
// Optional feature macro: HEALTH_BAR_FLASH_EN (filled segments blink while invulnerable)
//
// Ports:
//   clk, rst           pixel clock, asynchronous active-high reset
//   hcount_in          current pixel column (11 bits)
//   vcount_in          current pixel row (10 bits)
//   frame_tick         one-cycle pulse at start of each frame
//   damage_in          damage request level, acts on rising edge
//   damage_amt         HP to subtract, sampled on the damage edge (0 means 1)
//   heal_in            heal request level, acts on rising edge
//   hp_out             current HP
//   invuln_out         high while invulnerable after a hit
//   dead_out           high once HP reached zero (until reset)
//   pixel_out          registered RGB444 pixel, one cycle behind hcount/vcount

module segmented_health_bar #(
    parameter int          POS_X         = 480,
    parameter int          POS_Y         = 720,
    parameter int          SEG_W         = 16,
    parameter int          HEIGHT        = 32,
    parameter int          MAX_HP        = 6,
    parameter int          HP_W          = 4,
    parameter int          INVULN_FRAMES = 30,
    parameter int          LOW_HP        = 2,
    parameter logic [11:0] COLOR_FULL    = 12'hFF0,
    parameter logic [11:0] COLOR_LOW     = 12'hF80,
    parameter logic [11:0] COLOR_EMPTY   = 12'hF00
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [10:0]     hcount_in,
    input  logic [9:0]      vcount_in,
    input  logic            frame_tick,
    input  logic            damage_in,
    input  logic [HP_W-1:0] damage_amt,
    input  logic            heal_in,
    output logic [HP_W-1:0] hp_out,
    output logic            invuln_out,
    output logic            dead_out,
    output logic [11:0]     pixel_out
);

    localparam int SEG_SH = $clog2(SEG_W);
    localparam int TW     = $clog2(INVULN_FRAMES + 1);

    localparam logic [10:0]     X_LO   = 11'(POS_X);
    localparam logic [10:0]     X_HI   = 11'(POS_X + MAX_HP * SEG_W);
    localparam logic [9:0]      Y_LO   = 10'(POS_Y);
    localparam logic [9:0]      Y_HI   = 10'(POS_Y + HEIGHT);
    localparam logic [HP_W-1:0] HP_MAX = HP_W'(MAX_HP);
    localparam logic [HP_W-1:0] HP_LOW = HP_W'(LOW_HP);

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic            damage_q;
    logic            heal_q;

    logic            dmg_edge;
    logic            heal_edge;
    logic [HP_W-1:0] amt_eff;
    logic [HP_W-1:0] hp_healed;

    assign dmg_edge  = damage_in & ~damage_q;
    assign heal_edge = heal_in & ~heal_q;
    assign amt_eff   = (damage_amt == '0) ? HP_W'(1) : damage_amt;
    assign hp_healed = (hp_out >= HP_MAX) ? HP_MAX : hp_out + HP_W'(1);

    // Health state machine; outputs are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ALIVE;
            hp_out     <= HP_MAX;
            timer      <= '0;
            damage_q   <= 1'b0;
            heal_q     <= 1'b0;
            invuln_out <= 1'b0;
            dead_out   <= 1'b0;
        end else begin
            damage_q <= damage_in;
            heal_q   <= heal_in;
            case (state)
                ALIVE: begin
                    // Damage wins over a simultaneous heal.
                    if (dmg_edge) begin
                        if (amt_eff >= hp_out) begin
                            hp_out   <= '0;
                            state    <= DEAD;
                            dead_out <= 1'b1;
                        end else begin
                            hp_out     <= hp_out - amt_eff;
                            state      <= INVULN;
                            timer      <= TW'(INVULN_FRAMES);
                            invuln_out <= 1'b1;
                        end
                    end else if (heal_edge) begin
                        hp_out <= hp_healed;
                    end
                end
                INVULN: begin
                    if (heal_edge) begin
                        hp_out <= hp_healed;
                    end
                    if (frame_tick) begin
                        if (timer == TW'(1)) begin
                            state      <= ALIVE;
                            invuln_out <= 1'b0;
                        end
                        timer <= timer - TW'(1);
                    end
                end
                default: begin
                    hp_out <= '0;
                end
            endcase
        end
    end

`ifdef HEALTH_BAR_FLASH_EN
    logic [2:0] frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (frame_tick) begin
            frame_cnt <= frame_cnt + 3'd1;
        end
    end

    logic flash_off;
    assign flash_off = (state == INVULN) && frame_cnt[2];
`else
    logic flash_off;
    assign flash_off = 1'b0;
`endif

    logic [10:0] x_off;
    logic [10:0] seg_idx;
    logic        in_bar;
    logic        is_sep;
    logic [11:0] pixel_d;

    assign x_off   = hcount_in - X_LO;
    assign seg_idx = x_off >> SEG_SH;
    assign in_bar  = (hcount_in >= X_LO) && (hcount_in < X_HI) &&
                     (vcount_in >= Y_LO) && (vcount_in < Y_HI);
    // Last column of each segment is a black separator.
    assign is_sep  = (x_off[SEG_SH-1:0] == {SEG_SH{1'b1}});

    always_comb begin
        pixel_d = 12'h000;
        if (in_bar && !is_sep) begin
            if (seg_idx < {{(11-HP_W){1'b0}}, hp_out}) begin
                if (flash_off) begin
                    pixel_d = COLOR_EMPTY;
                end else if (hp_out <= HP_LOW) begin
                    pixel_d = COLOR_LOW;
                end else begin
                    pixel_d = COLOR_FULL;
                end
            end else begin
                pixel_d = COLOR_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_out <= 12'h000;
        end else begin
            pixel_out <= pixel_d;
        end
    end

endmodule

// File: tb/tb_segmented_health_bar.sv
// tb/tb_segmented_health_bar.sv - directed self-checking bench for segmented_health_bar

module tb_segmented_health_bar;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hcount_in = '0;
    logic [9:0]  vcount_in = '0;
    logic        frame_tick = 1'b0;
    logic        damage_in = 1'b0;
    logic [3:0]  damage_amt = '0;
    logic        heal_in = 1'b0;
    logic [3:0]  hp_out;
    logic        invuln_out;
    logic        dead_out;
    logic [11:0] pixel_out;

    int checks = 0;
    int errors = 0;

    segmented_health_bar dut (
        .clk        (clk),
        .rst        (rst),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .frame_tick (frame_tick),
        .damage_in  (damage_in),
        .damage_amt (damage_amt),
        .heal_in    (heal_in),
        .hp_out     (hp_out),
        .invuln_out (invuln_out),
        .dead_out   (dead_out),
        .pixel_out  (pixel_out)
    );

    always #5 clk = ~clk;

    // Stimulus helpers: inputs change on the falling edge, outputs are read on the next falling edge.
    task automatic present(input logic [10:0] h, input logic [9:0] v);
        @(negedge clk);
        hcount_in = h;
        vcount_in = v;
        @(negedge clk);
    endtask

    task automatic pulse(input logic dmg, input logic [3:0] amt, input logic heal);
        @(negedge clk);
        damage_in  = dmg;
        damage_amt = amt;
        heal_in    = heal;
        @(negedge clk);
        damage_in = 1'b0;
        heal_in   = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] hs [9] = '{481, 495, 575, 576, 479, 480, 481, 481, 481};
        logic [9:0]  vs [9] = '{730, 730, 730, 730, 730, 720, 719, 751, 752};
        logic [11:0] ex [9] = '{12'hFF0, 12'h000, 12'h000, 12'h000, 12'h000,
                                12'hFF0, 12'h000, 12'hFF0, 12'h000};
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (hp_out !== 4'd6 || invuln_out !== 1'b0 || dead_out !== 1'b0 || pixel_out !== 12'h000) begin
            errors++;
            $display("FAIL reset_state hp=%0d inv=%b dead=%b pix=%h exp hp=6 inv=0 dead=0 pix=000",
                     hp_out, invuln_out, dead_out, pixel_out);
        end
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            present(hs[i], vs[i]);
            checks++;
            if (pixel_out !== ex[i]) begin
                errors++;
                $display("FAIL reset_pix(%0d,%0d) got %h exp %h", hs[i], vs[i], pixel_out, ex[i]);
            end
        end
    endtask

    task automatic test_damage();
        pulse(1'b1, 4'd1, 1'b0);
        checks++;
        if (hp_out !== 4'd5 || invuln_out !== 1'b1) begin
            errors++;
            $display("FAIL damage1 hp=%0d inv=%b exp hp=5 inv=1", hp_out, invuln_out);
        end
        present(560, 730);
        checks++;
        if (pixel_out !== 12'hF00) begin
            errors++;
            $display("FAIL damage1_pix560 got %h exp F00", pixel_out);
        end
        present(544, 730);
        checks++;
        if (pixel_out !== 12'hFF0) begin
            errors++;
            $display("FAIL damage1_pix544 got %h exp FF0", pixel_out);
        end
    endtask

    task automatic test_invuln();
        pulse(1'b1, 4'd1, 1'b0);
        checks++;
        if (hp_out !== 4'd5) begin
            errors++;
            $display("FAIL invuln_ignore hp=%0d exp 5", hp_out);
        end
        ticks(29);
        checks++;
        if (invuln_out !== 1'b1) begin
            errors++;
            $display("FAIL invuln_29ticks inv=%b exp 1", invuln_out);
        end
        ticks(1);
        checks++;
        if (invuln_out !== 1'b0) begin
            errors++;
            $display("FAIL invuln_30ticks inv=%b exp 0", invuln_out);
        end
        pulse(1'b1, 4'd1, 1'b0);
        checks++;
        if (hp_out !== 4'd4 || invuln_out !== 1'b1) begin
            errors++;
            $display("FAIL damage_after_expiry hp=%0d inv=%b exp hp=4 inv=1", hp_out, invuln_out);
        end
        ticks(30);
    endtask

    task automatic test_zero_amt();
        pulse(1'b1, 4'd0, 1'b0);
        checks++;
        if (hp_out !== 4'd3) begin
            errors++;
            $display("FAIL zero_amt hp=%0d exp 3", hp_out);
        end
        present(481, 730);
        checks++;
        if (pixel_out !== 12'hFF0) begin
            errors++;
            $display("FAIL zero_amt_pix got %h exp FF0", pixel_out);
        end
        ticks(30);
    endtask

    task automatic test_simultaneous();
        pulse(1'b1, 4'd1, 1'b0);
        ticks(30);
        checks++;
        if (hp_out !== 4'd2 || invuln_out !== 1'b0) begin
            errors++;
            $display("FAIL setup_hp2 hp=%0d inv=%b exp hp=2 inv=0", hp_out, invuln_out);
        end
        pulse(1'b1, 4'd1, 1'b1);
        checks++;
        if (hp_out !== 4'd1) begin
            errors++;
            $display("FAIL dmg_heal_same hp=%0d exp 1", hp_out);
        end
        present(481, 730);
        checks++;
        if (pixel_out !== 12'hF80) begin
            errors++;
            $display("FAIL low_pix got %h exp F80", pixel_out);
        end
        ticks(30);
        pulse(1'b0, 4'd0, 1'b1);
        checks++;
        if (hp_out !== 4'd2 || invuln_out !== 1'b0) begin
            errors++;
            $display("FAIL heal_alive hp=%0d inv=%b exp hp=2 inv=0", hp_out, invuln_out);
        end
    endtask

    task automatic test_dead();
        pulse(1'b1, 4'd7, 1'b0);
        checks++;
        if (hp_out !== 4'd0 || dead_out !== 1'b1 || invuln_out !== 1'b0) begin
            errors++;
            $display("FAIL dead hp=%0d dead=%b inv=%b exp hp=0 dead=1 inv=0", hp_out, dead_out, invuln_out);
        end
        for (int i = 0; i < 6; i++) begin
            present(11'(480 + 16 * i + 1), 730);
            checks++;
            if (pixel_out !== 12'hF00) begin
                errors++;
                $display("FAIL dead_seg%0d got %h exp F00", i, pixel_out);
            end
        end
        pulse(1'b0, 4'd0, 1'b1);
        pulse(1'b1, 4'd1, 1'b0);
        checks++;
        if (hp_out !== 4'd0 || dead_out !== 1'b1) begin
            errors++;
            $display("FAIL dead_terminal hp=%0d dead=%b exp hp=0 dead=1", hp_out, dead_out);
        end
        // Assert reset between clock edges; outputs must clear before the next rising edge.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (hp_out !== 4'd6 || dead_out !== 1'b0) begin
            errors++;
            $display("FAIL async_reset hp=%0d dead=%b exp hp=6 dead=0", hp_out, dead_out);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_heal_edges();
        do_reset();
        pulse(1'b0, 4'd0, 1'b1);
        checks++;
        if (hp_out !== 4'd6) begin
            errors++;
            $display("FAIL heal_saturate hp=%0d exp 6", hp_out);
        end
        pulse(1'b1, 4'd1, 1'b0);
        ticks(29);
        // Heal together with the expiring tick: both must take effect.
        @(negedge clk);
        heal_in    = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        heal_in    = 1'b0;
        frame_tick = 1'b0;
        checks++;
        if (hp_out !== 4'd6 || invuln_out !== 1'b0) begin
            errors++;
            $display("FAIL heal_with_expiry hp=%0d inv=%b exp hp=6 inv=0", hp_out, invuln_out);
        end
        // Held level must not act again.
        @(negedge clk);
        damage_in  = 1'b1;
        damage_amt = 4'd2;
        repeat (4) @(negedge clk);
        damage_in = 1'b0;
        checks++;
        if (hp_out !== 4'd4) begin
            errors++;
            $display("FAIL level_held hp=%0d exp 4", hp_out);
        end
    endtask

`ifdef HEALTH_BAR_FLASH_EN
    task automatic test_flash();
        logic [11:0] exp_pix;
        do_reset();
        pulse(1'b1, 4'd1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            present(481, 730);
            exp_pix = (k >= 4) ? 12'hF00 : 12'hFF0;
            checks++;
            if (pixel_out !== exp_pix) begin
                errors++;
                $display("FAIL flash_frame%0d got %h exp %h", k, pixel_out, exp_pix);
            end
            ticks(1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_damage();
        test_invuln();
        test_zero_amt();
        test_simultaneous();
        test_dead();
        test_heal_edges();
`ifdef HEALTH_BAR_FLASH_EN
        test_flash();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
